// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential binary-to-BCD converter using the shift-add-3 (double-dabble)
// method. It converts the zero-extended sum word from the adder datapath
// into packed BCD digits for the seven-segment decode. Each conversion is
// started with a start/busy/done handshake and takes one shift per input
// bit.
//
// Parameters:
//   WIDTH  - bit width of the binary input (>= 1)
//   DIGITS - number of BCD output digits (>= 1)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   conversion request, sampled only while idle
//   bin    in   binary operand, captured on the accepting edge
//   busy   out  high while a conversion is shifting
//   done   out  one-cycle pulse; bcd/ovf are valid from this cycle on
//   bcd    out  packed BCD result, digit 0 in bits [3:0]
//   ovf    out  result exceeded 10^DIGITS-1; bcd holds the truncated digits
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t          state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    scratch;
   logic             sticky;
   logic [CW-1:0]    count;

   // Next values of one shift iteration.
   logic [BW-1:0]    adj;
   logic [BW-1:0]    scratch_nxt;
   logic [WIDTH-1:0] shreg_nxt;
   logic             sticky_nxt;

   // Add-3 correction on every digit, then shift {scratch, shreg} left by
   // one. The bit pushed out of the top digit is a carry into a digit we do
   // not have, so it is folded into the sticky overflow flag.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update,
      // so no path leaves it unassigned and no latch is inferred.
      adj = scratch;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
         end
      end
      scratch_nxt = {adj[BW-2:0], shreg[WIDTH-1]};
      shreg_nxt   = shreg << 1;
      sticky_nxt  = sticky | adj[BW-1];
   end

   // NOTE: every register here, including the datapath scratch, is cleared
   // by reset so that an aborted conversion leaves no stale digits behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         scratch <= '0;
         sticky  <= 1'b0;
         count   <= '0;
         bcd     <= '0;
         ovf     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so
         // every right-hand side sees the values from before this edge.
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  shreg   <= bin;
                  scratch <= '0;
                  sticky  <= 1'b0;
                  count   <= CW'(WIDTH);
                  state   <= ST_SHIFT;
                  busy    <= 1'b1;
               end
            end

            ST_SHIFT: begin
               shreg   <= shreg_nxt;
               scratch <= scratch_nxt;
               sticky  <= sticky_nxt;
               count   <= count - CW'(1);
               // Last shift: publish the result straight from the next
               // values so bcd/ovf are valid together with done.
               if (count == CW'(1)) begin
                  bcd   <= scratch_nxt;
                  ovf   <= sticky_nxt;
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end

            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule
